sbox_subst_engine: RTL and testbench

SBOX_SUBST_ENGINE -- requirements
Module: sbox_subst_engine

---
 rtl/sbox_subst_engine.sv | 132 +++++++++++++
 tb/tb_sbox_subst_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_subst_engine.sv
// DES S-box substitution engine: evaluates LANES of the eight S-boxes per cycle,
// so a 48-bit key-mixed half-block takes GROUPS = 8/LANES BUSY cycles.
module sbox_subst_engine #(
    parameter int unsigned LANES = 8,
    localparam int unsigned GROUPS = 8 / LANES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [47:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_busy
);

    localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Each entry holds rows 0..3 of one S-box, 16 nibbles per row, row 0 col 0 in the MSBs.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("sbox_subst_engine: LANES must be 1, 2, 4 or 8");
    end

    // Row {b5,b0} and column b4..b1 form a 6-bit nibble index into the box table.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] x);
        logic [255:0] shifted;
        shifted = SBOX_TBL[box] << {x[5], x[0], x[4:1], 2'b00};
        return shifted[255:252];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [47:0]   data_q, data_d;
    logic [31:0]   result_q, result_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [31:0]   lane_result;

    // Merge the current group's S-box nibbles into the result word.
    always_comb begin : p_lanes
        logic [2:0] box;
        logic [5:0] sel;
        logic [4:0] sh;
        box         = '0;
        sel         = '0;
        sh          = '0;
        lane_result = result_q;
        for (int l = 0; l < LANES; l++) begin
            box = 3'(32'(grp_q) * LANES + 32'(l));
            sel = 6'(data_q >> (6'd42 - 6'(box) * 6'd6));
            sh  = 5'd28 - 5'(box) * 5'd4;
            lane_result = (lane_result & ~(32'hF << sh)) | (32'(sbox_lookup(box, sel)) << sh);
        end
    end

    always_comb begin : p_next
        state_d  = state_q;
        grp_d    = grp_q;
        data_d   = data_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_in_valid) begin
                    state_d = ST_BUSY;
                    grp_d   = '0;
                    data_d  = i_in_data;
                end
            end
            ST_BUSY: begin
                result_d = lane_result;
                if (grp_q == GW'(GROUPS - 1)) begin
                    state_d = ST_DONE;
                    grp_d   = '0;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_BUSY);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            data_q      <= data_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = result_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_sbox_subst_engine.sv
// Bench for sbox_subst_engine: four instances (LANES 1,2,4,8) checked against
// an arithmetic DES S-box model, with directed, sweep, stall, reset and random-stream tests.
module tb_sbox_subst_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [3:0][47:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [3:0][31:0] out_data;
    logic [3:0]       busy;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        sbox_subst_engine #(.LANES(1 << gi)) u_dut (
            .i_clk      (clk),
            .i_rst      (rst[gi]),
            .i_in_valid (in_valid[gi]),
            .o_in_ready (in_ready[gi]),
            .i_in_data  (in_data[gi]),
            .o_out_valid(out_valid[gi]),
            .i_out_ready(out_ready[gi]),
            .o_out_data (out_data[gi]),
            .o_busy     (busy[gi])
        );
    end

    // FIPS 46-3 S1..S8, row-major (row*16 + column).
    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [47:0] x);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int six;
            int row;
            int col;
            six = int'((x >> (42 - 6 * k)) & 48'h3F);
            row = (six / 32) * 2 + (six % 2);
            col = (six / 2) % 16;
            r   = r | (32'(sb[k][row * 16 + col]) << (28 - 4 * k));
        end
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    function automatic int groups_of(input int d);
        return 8 >> d;
    endfunction

    // One block through instance d, optional output stall, then output handshake.
    task automatic send_block(input int d, input logic [47:0] data, input logic [31:0] exp, input int stall);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        check_eq("pre_in_ready", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = rand48();
        check_eq("accept_in_ready", 32'(in_ready[d]), 32'd0);
        while (!out_valid[d] && lat < 40) begin
            bcnt += int'(busy[d]);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(groups_of(d)));
        check_eq("busy_cycles", 32'(bcnt), 32'(groups_of(d)));
        check_eq("out_data", out_data[d], exp);
        for (int s = 0; s < stall; s++) begin
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = rand48();
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid[d]), 32'd1);
            check_eq("stall_data", out_data[d], exp);
            check_eq("stall_in_ready", 32'(in_ready[d]), 32'd0);
            check_eq("stall_busy", 32'(busy[d]), 32'd0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_eq("release_in_ready", 32'(in_ready[d]), 32'd1);
        check_eq("release_valid", 32'(out_valid[d]), 32'd0);
        check_eq("hold_data", out_data[d], exp);
    endtask

    // Random valid/ready traffic with an in-order scoreboard.
    task automatic stream_test(input int d, input int n_blocks);
        logic [31:0] expq [$];
        logic [47:0] dat;
        int sent;
        int got;
        int cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < n_blocks || got < n_blocks) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            out_ready[d] = ($urandom_range(0, 3) != 0);
            in_valid[d]  = (sent < n_blocks) && ($urandom_range(0, 2) != 0);
            dat          = rand48();
            in_data[d]   = dat;
            if (in_valid[d] && in_ready[d]) begin
                expq.push_back(model(dat));
                sent++;
            end
            if (out_valid[d] && out_ready[d]) begin
                check_eq("stream_expected_pending", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    check_eq("stream_data", out_data[d], expq.pop_front());
                end
                got++;
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        repeat (4) @(negedge clk);
        out_ready[d] = 1'b0;
        check_eq("stream_sent", 32'(sent), 32'(n_blocks));
        check_eq("stream_got", 32'(got), 32'(n_blocks));
        check_eq("stream_drain_valid", 32'(out_valid[d]), 32'd0);
        check_eq("stream_drain_in_ready", 32'(in_ready[d]), 32'd1);
    endtask

    // Reset lands on the second BUSY cycle of a LANES=2 block.
    task automatic reset_mid_busy();
        int seen;
        seen = 0;
        in_valid[1] = 1'b1;
        in_data[1]  = rand48();
        @(negedge clk);
        in_valid[1] = 1'b0;
        check_eq("rst_busy1", 32'(busy[1]), 32'd1);
        @(negedge clk);
        check_eq("rst_busy2", 32'(busy[1]), 32'd1);
        rst[1]       = 1'b1;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready[1]), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid[1]), 32'd0);
        check_eq("rst_out_data", out_data[1], 32'h0);
        check_eq("rst_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        rst[1]      = 1'b0;
        in_valid[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid[1] || busy[1] || out_data[1] != 32'h0) seen++;
        end
        out_ready[1] = 1'b0;
        check_eq("rst_no_stale", 32'(seen), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [47:0] data;
        rst       = '1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        for (int d = 0; d < 4; d++) in_data[d] = rand48();
        in_valid  = '1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_eq("reset_in_ready", 32'(in_ready[d]), 32'd1);
            check_eq("reset_out_valid", 32'(out_valid[d]), 32'd0);
            check_eq("reset_busy", 32'(busy[d]), 32'd0);
            check_eq("reset_out_data", out_data[d], 32'h0);
        end
        in_valid = '0;
        rst      = '0;
        @(negedge clk);

        send_block(3, 48'h0, 32'hEFA72C4D, 0);
        send_block(3, 48'h21, 32'hEFA72C42, 0);
        send_block(3, 48'h1E, 32'hEFA72C47, 0);
        send_block(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 0);

        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 8; k++) begin
                for (int c = 0; c < 64; c++) begin
                    data = 48'(c) << (42 - 6 * k);
                    send_block(d, data, model(data), 0);
                end
            end
        end

        data = rand48();
        send_block(2, data, model(data), 20);
        data = rand48();
        send_block(0, data, model(data), 3);

        reset_mid_busy();

        for (int d = 0; d < 4; d++) stream_test(d, 60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
